// File: rtl/uart_rx_frame_decoder.sv
// UART receive bit/frame engine: mid-bit oversampled deserializer with parity/stop checks
// and a valid/ready output register that drops and flags words arriving while one is held.
module uart_rx_frame_decoder #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_en,
    input  logic                 i_rx,
    input  logic                 i_rx_fall,
    input  logic                 i_baud_tick,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    input  logic                 i_stop2,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitsLast = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_second_q, stop_second_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 done_q, done_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 load;

    logic                 at_half;
    logic                 at_full;
    logic [TickW-1:0]     tick_inc;

    assign at_half  = i_baud_tick && (tick_q == HalfLast);
    assign at_full  = i_baud_tick && (tick_q == FullLast);
    assign tick_inc = i_baud_tick ? tick_q + TickW'(1) : tick_q;

    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        par_en_d      = par_en_q;
        par_odd_d     = par_odd_q;
        stop2_d       = stop2_q;
        stop_second_d = stop_second_q;
        ferr_d        = ferr_q;
        perr_d        = perr_q;
        done_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_en && i_rx_fall) begin
                    state_d       = StStart;
                    tick_d        = '0;
                    bit_d         = '0;
                    par_en_d      = i_parity_en;
                    par_odd_d     = i_parity_odd;
                    stop2_d       = i_stop2;
                    stop_second_d = 1'b0;
                    ferr_d        = 1'b0;
                    perr_d        = 1'b0;
                end
            end
            StStart: begin
                tick_d = tick_inc;
                if (at_half) begin
                    tick_d  = '0;
                    // A high line at mid-start is a glitch, not a frame.
                    state_d = i_rx ? StIdle : StData;
                end
            end
            StData: begin
                tick_d = tick_inc;
                if (at_full) begin
                    tick_d  = '0;
                    shift_d = {i_rx, shift_q[DATA_BITS-1:1]};
                    if (bit_q == BitsLast) begin
                        state_d = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                tick_d = tick_inc;
                if (at_full) begin
                    tick_d  = '0;
                    perr_d  = ((^shift_q) ^ i_rx) != par_odd_q;
                    state_d = StStop;
                end
            end
            StStop: begin
                tick_d = tick_inc;
                if (at_full) begin
                    tick_d = '0;
                    ferr_d = ferr_q | ~i_rx;
                    if (stop2_q && !stop_second_q) begin
                        stop_second_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!i_en) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    // Output stage: a completed word loads only if the slot is free or being freed now.
    always_comb begin
        load       = done_q && (!valid_q || i_ready);
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_out_d = ferr_out_q;
        perr_out_d = perr_out_q;
        ovr_d      = done_q && !load;
        if (load) begin
            data_d     = shift_q;
            valid_d    = 1'b1;
            ferr_out_d = ferr_q;
            perr_out_d = perr_q;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q       <= StIdle;
            tick_q        <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            par_en_q      <= 1'b0;
            par_odd_q     <= 1'b0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
            ferr_q        <= 1'b0;
            perr_q        <= 1'b0;
            done_q        <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            ferr_out_q    <= 1'b0;
            perr_out_q    <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            par_en_q      <= par_en_d;
            par_odd_q     <= par_odd_d;
            stop2_q       <= stop2_d;
            stop_second_q <= stop_second_d;
            ferr_q        <= ferr_d;
            perr_q        <= perr_d;
            done_q        <= done_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            ferr_out_q    <= ferr_out_d;
            perr_out_q    <= perr_out_d;
            ovr_q         <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = ferr_out_q;
    assign o_parity_err = perr_out_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Directed bench for uart_rx_frame_decoder: frames are driven bit by bit, expected words are
// queued at issue time and a negedge monitor pops and compares on every accepted handshake.
module tb_uart_rx_frame_decoder;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CYC    = OVERSAMPLE * TICK_DIV;

    logic                 i_clk        = 1'b0;
    logic                 i_nrst       = 1'b0;
    logic                 i_en         = 1'b0;
    logic                 i_rx         = 1'b1;
    logic                 i_rx_fall    = 1'b0;
    logic                 i_parity_en  = 1'b0;
    logic                 i_parity_odd = 1'b0;
    logic                 i_stop2      = 1'b0;
    logic                 i_ready      = 1'b0;
    logic                 i_baud_tick;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
    logic                 o_parity_err;
    logic                 o_overrun;
    logic                 o_busy;

    logic [1:0] tick_cnt = 2'd0;

    int          checks    = 0;
    int          failures  = 0;
    int          ovr_count = 0;
    int          popped    = 0;
    int          since     = 99;
    int          ovr_base  = 0;
    bit          arm_ready = 1'b0;
    logic        busy_prev = 1'b0;
    logic        valid_prev = 1'b0;
    logic [9:0]  exp_q[$];

    uart_rx_frame_decoder #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_en        (i_en),
        .i_rx        (i_rx),
        .i_rx_fall   (i_rx_fall),
        .i_baud_tick (i_baud_tick),
        .i_parity_en (i_parity_en),
        .i_parity_odd(i_parity_odd),
        .i_stop2     (i_stop2),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) tick_cnt <= tick_cnt + 2'd1;
    assign i_baud_tick = (tick_cnt == 2'd3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, overrun pulse counting, completion-to-valid latency.
    always @(negedge i_clk) begin
        logic [9:0] e;
        if (busy_prev && !o_busy) since = 0;
        else if (since < 99) since++;
        if (o_valid && !valid_prev) check("valid_latency", since, 1);
        if (o_overrun) ovr_count++;
        if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got 0x%0h expected none", o_data);
            end else begin
                e = exp_q.pop_front();
                popped++;
                check("word_data", o_data, e[9:2]);
                check("word_frame_err", o_frame_err, e[1]);
                check("word_parity_err", o_parity_err, e[0]);
            end
        end
        busy_prev  = o_busy;
        valid_prev = o_valid;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        i_rx_fall = 1'b0;
        // Raise ready in the completion cycle (first cycle the engine is idle again).
        if (arm_ready && !o_busy) begin
            i_ready   = 1'b1;
            arm_ready = 1'b0;
        end
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    // abort_mode: 0 none, 1 drop i_en at data bit 3, 2 pulse i_nrst at data bit 3.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit podd, input bit s2,
                              input logic pbit, input logic s1b, input logic s2b,
                              input bit arm, input int abort_mode);
        i_parity_en  = pen;
        i_parity_odd = podd;
        i_stop2      = s2;
        i_rx         = 1'b0;
        i_rx_fall    = 1'b1;
        hold(BIT_CYC);
        // Config changes mid-frame must be ignored.
        i_parity_en  = ~pen;
        i_parity_odd = ~podd;
        i_stop2      = ~s2;
        for (int k = 0; k < 8; k++) begin
            i_rx = d[k];
            if (abort_mode != 0 && k == 3) begin
                hold(BIT_CYC / 2);
                if (abort_mode == 1) begin
                    i_en = 1'b0;
                    hold(2);
                    check("abort_en_busy", o_busy, 0);
                    check("abort_en_valid", o_valid, 0);
                    i_en = 1'b1;
                end else begin
                    i_nrst = 1'b0;
                    #1;
                    check("abort_rst_busy", o_busy, 0);
                    check("abort_rst_valid", o_valid, 0);
                    hold(2);
                    i_nrst = 1'b1;
                end
                i_rx = 1'b1;
                hold(BIT_CYC * 8);
                return;
            end
            hold(BIT_CYC);
        end
        if (pen) begin
            i_rx = pbit;
            hold(BIT_CYC);
        end
        arm_ready = arm;
        i_rx = s1b;
        hold(BIT_CYC);
        if (s2) begin
            i_rx = s2b;
            hold(BIT_CYC);
        end
        i_rx = 1'b1;
        hold(BIT_CYC / 2);
    endtask

    initial begin
        hold(3);
        check("rst_valid", o_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_data", o_data, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_parity_err", o_parity_err, 0);
        i_nrst  = 1'b1;
        i_en    = 1'b1;
        i_ready = 1'b1;
        hold(5);

        // 8N1
        exp_q.push_back({8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
        // 8E1 with wrong, then right, parity bit; then 8O1
        exp_q.push_back({8'h07, 1'b0, 1'b1});
        send_frame(8'h07, 1, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
        exp_q.push_back({8'h07, 1'b0, 1'b0});
        send_frame(8'h07, 1, 0, 0, 1'b1, 1'b1, 1'b1, 0, 0);
        exp_q.push_back({8'h07, 1'b0, 1'b0});
        send_frame(8'h07, 1, 1, 0, 1'b0, 1'b1, 1'b1, 0, 0);
        // Break, then two stop bits with the second low
        exp_q.push_back({8'h00, 1'b1, 1'b0});
        send_frame(8'h00, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, 0);
        exp_q.push_back({8'h5A, 1'b1, 1'b0});
        send_frame(8'h5A, 0, 0, 1, 1'b0, 1'b1, 1'b0, 0, 0);

        // 4-tick glitch: false start
        i_rx      = 1'b0;
        i_rx_fall = 1'b1;
        hold(4 * TICK_DIV);
        check("glitch_busy_high", o_busy, 1);
        i_rx = 1'b1;
        hold(BIT_CYC);
        check("glitch_back_idle", o_busy, 0);
        check("glitch_no_valid", o_valid, 0);

        // Overrun: second word dropped while the first is held
        i_ready  = 1'b0;
        ovr_base = ovr_count;
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
        send_frame(8'h22, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
        check("overrun_hold_data", o_data, 8'h11);
        check("overrun_hold_valid", o_valid, 1);
        check("overrun_pulses", ovr_count - ovr_base, 1);
        // Ready in the completion cycle: accept and reload, no overrun
        exp_q.push_back({8'h22, 1'b0, 1'b0});
        send_frame(8'h22, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1, 0);
        hold(4);
        check("reload_no_overrun", ovr_count - ovr_base, 1);
        check("reload_drained", o_valid, 0);

        // Aborts at data bit 3, each followed by a clean frame
        send_frame(8'hE7, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 1);
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0);
        send_frame(8'hE7, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 2);
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 0, 0, 0, 1'b0, 1'b1, 1'b1, 0, 0);

        hold(10);
        check("queue_empty", exp_q.size(), 0);
        check("words_seen", popped, 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
